ctrl_pipe: RTL and testbench

Parameterised control pipeline behind the decoder. It accepts one decoded control bundle per cycle from ID and carries it through STAGES registered stages (stage 0 = EX … stage STAGES-1 = WB). It detects load-use hazards and inserts bubbles, squashes on flush, and freezes on memory stall. It also produces EX-stage forwarding selects and a saturating bubble counter.

---
 rtl/ctrl_pipe.sv | 154 +++++++++++++++
 tb/tb_ctrl_pipe.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: control pipeline that sits behind the decoder.
// Carries one decoded control bundle per cycle through STAGES registered stages
// (stage 0 = EX ... stage STAGES-1 = WB). It inserts a bubble on a load-use hazard,
// squashes the ID bundle on flush and freezes every stage on mem_stall. It also
// produces the EX-stage forwarding selects and a saturating hazard-bubble counter.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   id_*               decoded bundle presented by ID; id_ready = accepted or flushed
//   flush              squash the ID bundle (ignored while mem_stall is high)
//   mem_stall          hold every stage
//   st_valid/regwen    per-stage flags, bit k = stage k (regwen masked by valid)
//   st_rd/st_payload   per-stage fields, stage k in slice [k*W +: W]
//   fwd_a/fwd_b        EX operand source: 0 = regfile, k = stage k result
//   load_use_stall     a hazard bubble is being inserted this cycle
//   bubble_cnt         saturating count of hazard bubbles
module ctrl_pipe #(
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned STAGES    = 3,
  parameter int unsigned PAYLOAD_W = 11,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned FW        = $clog2(STAGES)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          id_valid,
  output logic                          id_ready,
  input  logic [REG_AW-1:0]             id_rs1,
  input  logic [REG_AW-1:0]             id_rs2,
  input  logic                          id_uses_rs1,
  input  logic                          id_uses_rs2,
  input  logic [REG_AW-1:0]             id_rd,
  input  logic                          id_regwen,
  input  logic                          id_is_load,
  input  logic [PAYLOAD_W-1:0]          id_payload,
  input  logic                          flush,
  input  logic                          mem_stall,
  output logic [STAGES-1:0]             st_valid,
  output logic [STAGES-1:0]             st_regwen,
  output logic [STAGES*REG_AW-1:0]      st_rd,
  output logic [STAGES*PAYLOAD_W-1:0]   st_payload,
  output logic [FW-1:0]                 fwd_a,
  output logic [FW-1:0]                 fwd_b,
  output logic                          load_use_stall,
  output logic [CNT_W-1:0]              bubble_cnt
);

  // Per-stage state. Packed so that element k lands in slice [k*W +: W] of the outputs.
  logic [STAGES-1:0]                valid_q;
  logic [STAGES-1:0]                regwen_q;
  logic [STAGES-1:0][REG_AW-1:0]    rd_q;
  logic [STAGES-1:0][PAYLOAD_W-1:0] payload_q;

  // Source/load information is only consulted in EX, so only stage 0 keeps it.
  logic              s0_uses_rs1_q;
  logic              s0_uses_rs2_q;
  logic [REG_AW-1:0] s0_rs1_q;
  logic [REG_AW-1:0] s0_rs2_q;
  logic              s0_is_load_q;

  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  logic hazard;
  logic s0_valid_d;

  // Load-use hazard: the EX-stage load produces a register that the ID bundle reads.
  always_comb begin
    hazard = id_valid && valid_q[0] && s0_is_load_q && regwen_q[0] && (rd_q[0] != '0) &&
             ((id_uses_rs1 && (id_rs1 == rd_q[0])) || (id_uses_rs2 && (id_rs2 == rd_q[0])));
  end

  always_comb begin
    load_use_stall = hazard && !flush && !mem_stall;
    id_ready       = !mem_stall && (flush || !hazard);
    // Flush and hazard both turn the incoming slot into a bubble.
    s0_valid_d     = id_valid && id_ready && !flush;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (load_use_stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q       <= '0;
      regwen_q      <= '0;
      rd_q          <= '0;
      payload_q     <= '0;
      s0_uses_rs1_q <= 1'b0;
      s0_uses_rs2_q <= 1'b0;
      s0_rs1_q      <= '0;
      s0_rs2_q      <= '0;
      s0_is_load_q  <= 1'b0;
    end else if (!mem_stall) begin
      for (int k = STAGES - 1; k >= 1; k--) begin
        valid_q[k]   <= valid_q[k-1];
        regwen_q[k]  <= regwen_q[k-1];
        rd_q[k]      <= rd_q[k-1];
        payload_q[k] <= payload_q[k-1];
      end
      // Empty slots carry all-zero fields so bubbles never alias a real producer.
      valid_q[0]    <= s0_valid_d;
      regwen_q[0]   <= s0_valid_d && id_regwen;
      rd_q[0]       <= s0_valid_d ? id_rd : '0;
      payload_q[0]  <= s0_valid_d ? id_payload : '0;
      s0_uses_rs1_q <= s0_valid_d && id_uses_rs1;
      s0_uses_rs2_q <= s0_valid_d && id_uses_rs2;
      s0_rs1_q      <= s0_valid_d ? id_rs1 : '0;
      s0_rs2_q      <= s0_valid_d ? id_rs2 : '0;
      s0_is_load_q  <= s0_valid_d && id_is_load;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Forwarding: scan oldest to youngest so the youngest matching producer wins.
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    for (int k = STAGES - 1; k >= 1; k--) begin
      if (valid_q[k] && regwen_q[k] && (rd_q[k] == s0_rs1_q)) begin
        fwd_a = FW'(k);
      end
      if (valid_q[k] && regwen_q[k] && (rd_q[k] == s0_rs2_q)) begin
        fwd_b = FW'(k);
      end
    end
    if (!valid_q[0] || !s0_uses_rs1_q || (s0_rs1_q == '0)) begin
      fwd_a = '0;
    end
    if (!valid_q[0] || !s0_uses_rs2_q || (s0_rs2_q == '0)) begin
      fwd_b = '0;
    end
  end

  always_comb begin
    st_valid   = valid_q;
    st_regwen  = valid_q & regwen_q;
    st_rd      = rd_q;
    st_payload = payload_q;
    bubble_cnt = cnt_q;
  end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed, table-driven bench for ctrl_pipe (STAGES = 3, CNT_W = 2).
// Each table row drives one ID cycle: combinational outputs are compared just before
// the edge, registered outputs just after it.
module tb_ctrl_pipe;

  localparam int unsigned REG_AW    = 5;
  localparam int unsigned STAGES    = 3;
  localparam int unsigned PAYLOAD_W = 11;
  localparam int unsigned CNT_W     = 2;
  localparam int unsigned FW        = 2;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        id_valid;
  logic                        id_ready;
  logic [REG_AW-1:0]           id_rs1;
  logic [REG_AW-1:0]           id_rs2;
  logic                        id_uses_rs1;
  logic                        id_uses_rs2;
  logic [REG_AW-1:0]           id_rd;
  logic                        id_regwen;
  logic                        id_is_load;
  logic [PAYLOAD_W-1:0]        id_payload;
  logic                        flush;
  logic                        mem_stall;
  logic [STAGES-1:0]           st_valid;
  logic [STAGES-1:0]           st_regwen;
  logic [STAGES*REG_AW-1:0]    st_rd;
  logic [STAGES*PAYLOAD_W-1:0] st_payload;
  logic [FW-1:0]               fwd_a;
  logic [FW-1:0]               fwd_b;
  logic                        load_use_stall;
  logic [CNT_W-1:0]            bubble_cnt;

  ctrl_pipe #(
    .REG_AW    (REG_AW),
    .STAGES    (STAGES),
    .PAYLOAD_W (PAYLOAD_W),
    .CNT_W     (CNT_W),
    .FW        (FW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_uses_rs1    (id_uses_rs1),
    .id_uses_rs2    (id_uses_rs2),
    .id_rd          (id_rd),
    .id_regwen      (id_regwen),
    .id_is_load     (id_is_load),
    .id_payload     (id_payload),
    .flush          (flush),
    .mem_stall      (mem_stall),
    .st_valid       (st_valid),
    .st_regwen      (st_regwen),
    .st_rd          (st_rd),
    .st_payload     (st_payload),
    .fwd_a          (fwd_a),
    .fwd_b          (fwd_b),
    .load_use_stall (load_use_stall),
    .bubble_cnt     (bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        u1;
    logic        u2;
    logic [4:0]  rd;
    logic        ld;
    logic        fl;
    logic        ms;
    logic        rdy;
    logic        lus;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [2:0]  sv;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [1:0]  cnt;
  } vec_t;

  vec_t vecs[$];
  vec_t cur;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Payload tags the bundle with its rd so stage contents can be tracked.
  task automatic drive(input int v, input int rs1, input int rs2, input int u1, input int u2,
                       input int rd, input int ld, input int fl, input int ms);
    id_valid    = v[0];
    id_rs1      = 5'(rs1);
    id_rs2      = 5'(rs2);
    id_uses_rs1 = u1[0];
    id_uses_rs2 = u2[0];
    id_rd       = 5'(rd);
    id_regwen   = v[0];
    id_is_load  = ld[0];
    id_payload  = {6'h15, 5'(rd)};
    flush       = fl[0];
    mem_stall   = ms[0];
  endtask

  task automatic row_in(input int v, input int rs1, input int rs2, input int u1, input int u2,
                        input int rd, input int ld, input int fl, input int ms);
    cur.v   = v[0];
    cur.rs1 = 5'(rs1);
    cur.rs2 = 5'(rs2);
    cur.u1  = u1[0];
    cur.u2  = u2[0];
    cur.rd  = 5'(rd);
    cur.ld  = ld[0];
    cur.fl  = fl[0];
    cur.ms  = ms[0];
  endtask

  task automatic row_ex(input int rdy, input int lus, input int fa, input int fb, input int sv,
                        input int r0, input int r1, input int r2, input int cnt);
    cur.rdy = rdy[0];
    cur.lus = lus[0];
    cur.fa  = 2'(fa);
    cur.fb  = 2'(fb);
    cur.sv  = 3'(sv);
    cur.r0  = 5'(r0);
    cur.r1  = 5'(r1);
    cur.r2  = 5'(r2);
    cur.cnt = 2'(cnt);
    vecs.push_back(cur);
  endtask

  task automatic idle_row(input int sv, input int r0, input int r1, input int r2, input int cnt,
                          input int fa, input int fb);
    row_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    row_ex(1, 0, fa, fb, sv, r0, r1, r2, cnt);
  endtask

  initial begin
    vec_t       t;
    logic [14:0]  exp_rd;
    logic [10:0]  exp_p0;
    logic [10:0]  exp_p1;

    // Independent ALU bundles rd = 1..4 then drain.
    row_in(1, 0, 0, 0, 0, 1, 0, 0, 0); row_ex(1, 0, 0, 0, 1, 1, 0, 0, 0);
    row_in(1, 0, 0, 0, 0, 2, 0, 0, 0); row_ex(1, 0, 0, 0, 3, 2, 1, 0, 0);
    row_in(1, 0, 0, 0, 0, 3, 0, 0, 0); row_ex(1, 0, 0, 0, 7, 3, 2, 1, 0);
    row_in(1, 0, 0, 0, 0, 4, 0, 0, 0); row_ex(1, 0, 0, 0, 7, 4, 3, 2, 0);
    idle_row(6, 0, 4, 3, 0, 0, 0);
    idle_row(4, 0, 0, 4, 0, 0, 0);
    idle_row(0, 0, 0, 0, 0, 0, 0);
    // rd = 5 producer, consumer rs1 = 5 directly behind: fwd_a = 1.
    row_in(1, 0, 0, 0, 0, 5, 0, 0, 0); row_ex(1, 0, 0, 0, 1, 5, 0, 0, 0);
    row_in(1, 5, 0, 1, 0, 6, 0, 0, 0); row_ex(1, 0, 0, 0, 3, 6, 5, 0, 0);
    idle_row(6, 0, 6, 5, 0, 1, 0);
    // Independent instruction in between: fwd_a = 2.
    row_in(1, 0, 0, 0, 0, 5, 0, 0, 0); row_ex(1, 0, 0, 0, 5, 5, 0, 6, 0);
    row_in(1, 0, 0, 0, 0, 8, 0, 0, 0); row_ex(1, 0, 0, 0, 3, 8, 5, 0, 0);
    row_in(1, 5, 0, 1, 0, 9, 0, 0, 0); row_ex(1, 0, 0, 0, 7, 9, 8, 5, 0);
    // Two producers of rd = 5 in stages 1 and 2: youngest (1) wins.
    row_in(1, 0, 0, 0, 0, 5, 0, 0, 0); row_ex(1, 0, 2, 0, 7, 5, 9, 8, 0);
    row_in(1, 0, 0, 0, 0, 5, 0, 0, 0); row_ex(1, 0, 0, 0, 7, 5, 5, 9, 0);
    row_in(1, 5, 0, 1, 0, 10, 0, 0, 0); row_ex(1, 0, 0, 0, 7, 10, 5, 5, 0);
    idle_row(6, 0, 10, 5, 0, 1, 0);
    idle_row(4, 0, 0, 10, 0, 0, 0);
    idle_row(0, 0, 0, 0, 0, 0, 0);
    // Load rd = 7, consumer rs2 = 7: one bubble, then fwd_b = 2.
    row_in(1, 0, 0, 0, 0, 7, 1, 0, 0); row_ex(1, 0, 0, 0, 1, 7, 0, 0, 0);
    row_in(1, 0, 7, 0, 1, 11, 0, 0, 0); row_ex(0, 1, 0, 0, 2, 0, 7, 0, 1);
    row_in(1, 0, 7, 0, 1, 11, 0, 0, 0); row_ex(1, 0, 0, 0, 5, 11, 0, 7, 1);
    idle_row(2, 0, 11, 0, 1, 0, 2);
    idle_row(4, 0, 0, 11, 1, 0, 0);
    idle_row(0, 0, 0, 0, 1, 0, 0);
    // Load to rd = 0 with a consumer of x0: no hazard, no forwarding.
    row_in(1, 0, 0, 0, 0, 0, 1, 0, 0); row_ex(1, 0, 0, 0, 1, 0, 0, 0, 1);
    row_in(1, 0, 0, 1, 1, 12, 0, 0, 0); row_ex(1, 0, 0, 0, 3, 12, 0, 0, 1);
    idle_row(6, 0, 12, 0, 1, 0, 0);
    idle_row(4, 0, 0, 12, 1, 0, 0);
    idle_row(0, 0, 0, 0, 1, 0, 0);
    // Flush on top of a load-use hazard: accepted, bubble, counter unchanged.
    row_in(1, 0, 0, 0, 0, 7, 1, 0, 0); row_ex(1, 0, 0, 0, 1, 7, 0, 0, 1);
    row_in(1, 7, 0, 1, 0, 13, 0, 1, 0); row_ex(1, 0, 0, 0, 2, 0, 7, 0, 1);
    idle_row(4, 0, 0, 7, 1, 0, 0);
    idle_row(0, 0, 0, 0, 1, 0, 0);
    // Fill, then mem_stall for 3 cycles with flush held: frozen, flush ignored.
    row_in(1, 0, 0, 0, 0, 14, 0, 0, 0); row_ex(1, 0, 0, 0, 1, 14, 0, 0, 1);
    row_in(1, 0, 0, 0, 0, 15, 0, 0, 0); row_ex(1, 0, 0, 0, 3, 15, 14, 0, 1);
    row_in(1, 0, 0, 0, 0, 16, 0, 0, 0); row_ex(1, 0, 0, 0, 7, 16, 15, 14, 1);
    for (int i = 0; i < 3; i++) begin
      row_in(1, 0, 0, 0, 0, 17, 0, 1, 1); row_ex(0, 0, 0, 0, 7, 16, 15, 14, 1);
    end
    row_in(1, 0, 0, 0, 0, 17, 0, 1, 0); row_ex(1, 0, 0, 0, 6, 0, 16, 15, 1);
    idle_row(4, 0, 0, 16, 1, 0, 0);
    idle_row(0, 0, 0, 0, 1, 0, 0);
    // Hazard under mem_stall is not a bubble; it becomes one once the stall drops.
    row_in(1, 0, 0, 0, 0, 3, 1, 0, 0); row_ex(1, 0, 0, 0, 1, 3, 0, 0, 1);
    row_in(1, 3, 0, 1, 0, 20, 0, 0, 1); row_ex(0, 0, 0, 0, 1, 3, 0, 0, 1);
    row_in(1, 3, 0, 1, 0, 20, 0, 0, 0); row_ex(0, 1, 0, 0, 2, 0, 3, 0, 2);
    row_in(1, 3, 0, 1, 0, 20, 0, 0, 0); row_ex(1, 0, 0, 0, 5, 20, 0, 3, 2);
    idle_row(2, 0, 20, 0, 2, 2, 0);
    idle_row(4, 0, 0, 20, 2, 0, 0);
    idle_row(0, 0, 0, 0, 2, 0, 0);

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #12;
    check("reset_st_valid", 64'(st_valid), 64'd0);
    check("reset_st_regwen", 64'(st_regwen), 64'd0);
    check("reset_st_rd", 64'(st_rd), 64'd0);
    check("reset_st_payload", 64'(st_payload), 64'd0);
    check("reset_bubble_cnt", 64'(bubble_cnt), 64'd0);
    check("reset_id_ready", 64'(id_ready), 64'd1);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      t = vecs[i];
      drive(t.v, t.rs1, t.rs2, t.u1, t.u2, t.rd, t.ld, t.fl, t.ms);
      #1;
      check($sformatf("row%0d_id_ready", i), 64'(id_ready), 64'(t.rdy));
      check($sformatf("row%0d_load_use_stall", i), 64'(load_use_stall), 64'(t.lus));
      check($sformatf("row%0d_fwd_a", i), 64'(fwd_a), 64'(t.fa));
      check($sformatf("row%0d_fwd_b", i), 64'(fwd_b), 64'(t.fb));
      @(posedge clk);
      #1;
      exp_rd = {t.r2, t.r1, t.r0};
      exp_p0 = t.sv[0] ? {6'h15, t.r0} : 11'd0;
      exp_p1 = t.sv[1] ? {6'h15, t.r1} : 11'd0;
      check($sformatf("row%0d_st_valid", i), 64'(st_valid), 64'(t.sv));
      check($sformatf("row%0d_st_regwen", i), 64'(st_regwen), 64'(t.sv));
      check($sformatf("row%0d_st_rd", i), 64'(st_rd), 64'(exp_rd));
      check($sformatf("row%0d_payload0", i), 64'(st_payload[10:0]), 64'(exp_p0));
      check($sformatf("row%0d_payload1", i), 64'(st_payload[21:11]), 64'(exp_p1));
      check($sformatf("row%0d_bubble_cnt", i), 64'(bubble_cnt), 64'(t.cnt));
    end

    // Reset mid-stream: takes effect without waiting for an edge, counter cleared.
    drive(1, 0, 0, 0, 0, 1, 0, 0, 0);
    @(posedge clk);
    #1;
    check("midrst_pre_valid", 64'(st_valid), 64'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_st_valid", 64'(st_valid), 64'd0);
    check("midrst_st_rd", 64'(st_rd), 64'd0);
    check("midrst_bubble_cnt", 64'(bubble_cnt), 64'd0);
    rst = 1'b0;

    // Five load-use pairs: the 2-bit counter stops at 3.
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 0, 0, 7, 1, 0, 0);
      @(posedge clk);
      #1;
      drive(1, 0, 7, 0, 1, 11, 0, 0, 0);
      #1;
      check($sformatf("sat%0d_load_use_stall", i), 64'(load_use_stall), 64'd1);
      check($sformatf("sat%0d_id_ready", i), 64'(id_ready), 64'd0);
      @(posedge clk);
      #1;
      check($sformatf("sat%0d_bubble_cnt", i), 64'(bubble_cnt), 64'((i + 1 > 3) ? 3 : i + 1));
      @(posedge clk);
      #1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
    end
    check("sat_final_bubble_cnt", 64'(bubble_cnt), 64'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
